// File: rtl/mwc_pkg.sv
// ---------------------------------------------------------------------------
// mwc_pkg
// Shared types and constants for the memory-write checker.
//   state_e     : checker FSM states
//   ST_*        : encodings driven on the 2-bit status output
// ---------------------------------------------------------------------------
package mwc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TMO
    } state_e;

    localparam logic [1:0] ST_RUN      = 2'b00;  // also used while idle
    localparam logic [1:0] ST_PASS     = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

endpackage

// File: rtl/mem_write_checker_if.sv
// ---------------------------------------------------------------------------
// mem_write_checker_if
// Data-memory store bus observed by the checker.
//   memwrite  : store strobe
//   dataadr   : store address
//   writedata : store data
// Modports: master (the processor driving the bus), slave (the checker).
// ---------------------------------------------------------------------------
interface mem_write_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;

    modport master (output memwrite, dataadr, writedata);
    modport slave  (input  memwrite, dataadr, writedata);

endinterface

// File: rtl/mwc_table.sv
// ---------------------------------------------------------------------------
// mwc_table
// Expected-store table: DEPTH entries of {address, data}.
//   clk          : rising-edge clock
//   we           : write enable for entry widx
//   widx/waddr/wdata : write port
//   ridx         : combinational read index
//   raddr/rdata  : entry at ridx
// ---------------------------------------------------------------------------
module mwc_table #(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // NOTE: storage has no reset; the table survives reset and clear so a
    // check can be re-run without reloading it.
    always_ff @(posedge clk) begin
        if (we) begin
            addr_mem[widx] <= waddr;
            data_mem[widx] <= wdata;
        end
    end

    assign raddr = addr_mem[ridx];
    assign rdata = data_mem[ridx];

endmodule

// File: rtl/mem_write_checker.sv
// ---------------------------------------------------------------------------
// mem_write_checker
// Monitors the processor store bus against an ordered table of expected
// stores, skipping stores inside an ignore window, with an optional timeout.
//   clk, reset        : clock, synchronous active-low reset
//   cfg_we/idx/addr/data : table load (IDLE only)
//   start, exp_count, ign_lo, ign_hi : begin a check (IDLE only)
//   clear             : return to IDLE from any state
//   bus               : observed store bus (slave modport)
//   done, pass, status: verdict
//   fail_idx/addr/data: failure details
//   match_cnt         : entries matched so far
// ---------------------------------------------------------------------------
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 1024,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic [IDX_W:0]    exp_count,
    input  logic [ADDR_W-1:0] ign_lo,
    input  logic [ADDR_W-1:0] ign_hi,
    input  logic              clear,
    mem_write_checker_if.slave bus,
    output logic              done,
    output logic              pass,
    output logic [1:0]        status,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W:0]    match_cnt
);

    localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]    DEPTH_C  = (IDX_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0] ign_lo_q, ign_lo_d, ign_hi_q, ign_hi_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [IDX_W:0]    match_cnt_q, match_cnt_d;
    logic              done_q, done_d, pass_q, pass_d;
    logic [1:0]        status_q, status_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic              table_we;
    logic [IDX_W-1:0]  ptr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              in_window, hit;

    // Entries are consumed strictly in order, so the read pointer is simply
    // the number of entries matched so far.
    assign ptr      = match_cnt_q[IDX_W-1:0];
    assign table_we = cfg_we && reset && (state_q == IDLE);

    mwc_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_table (
        .clk   (clk),
        .we    (table_we),
        .widx  (cfg_idx),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .ridx  (ptr),
        .raddr (exp_addr),
        .rdata (exp_data)
    );

    // An empty window (lo > hi) never contains anything. Case equality makes
    // an X/Z on the bus a mismatch rather than a silent pass in simulation.
    assign in_window = (bus.dataadr >= ign_lo_q) && (bus.dataadr <= ign_hi_q);
    assign hit       = (bus.dataadr === exp_addr) && (bus.writedata === exp_data);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ign_lo_d    = ign_lo_q;
        ign_hi_d    = ign_hi_q;
        timer_d     = timer_q;
        match_cnt_d = match_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        status_d    = status_q;
        fail_idx_d  = fail_idx_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d       = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
                    ign_lo_d    = ign_lo;
                    ign_hi_d    = ign_hi;
                    match_cnt_d = '0;
                    timer_d     = '0;
                    if (exp_count == '0) begin
                        state_d  = PASS;
                        done_d   = 1'b1;
                        pass_d   = 1'b1;
                        status_d = ST_PASS;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // A compared store outranks a timer expiring in the same cycle.
                if (bus.memwrite && !in_window) begin
                    if (hit) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        timer_d     = '0;
                        if ((match_cnt_q + 1'b1) == cnt_q) begin
                            state_d  = PASS;
                            done_d   = 1'b1;
                            pass_d   = 1'b1;
                            status_d = ST_PASS;
                        end
                    end else begin
                        state_d     = FAIL;
                        done_d      = 1'b1;
                        status_d    = ST_MISMATCH;
                        fail_idx_d  = ptr;
                        fail_addr_d = bus.dataadr;
                        fail_data_d = bus.writedata;
                    end
                end else if (TIMEOUT > 0) begin
                    if (timer_q == TMR_LAST) begin
                        state_d     = TMO;
                        done_d      = 1'b1;
                        status_d    = ST_TIMEOUT;
                        fail_idx_d  = ptr;
                        fail_addr_d = '0;
                        fail_data_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: ;  // PASS/FAIL/TMO hold until clear or reset
        endcase

        // clear wins over everything else, including a same-cycle start.
        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            ign_lo_d    = '0;
            ign_hi_d    = '0;
            timer_d     = '0;
            match_cnt_d = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            status_d    = ST_RUN;
            fail_idx_d  = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ign_lo_q    <= '0;
            ign_hi_q    <= '0;
            timer_q     <= '0;
            match_cnt_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            status_q    <= ST_RUN;
            fail_idx_q  <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ign_lo_q    <= ign_lo_d;
            ign_hi_q    <= ign_hi_d;
            timer_q     <= timer_d;
            match_cnt_q <= match_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            status_q    <= status_d;
            fail_idx_q  <= fail_idx_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign status    = status_q;
    assign fail_idx  = fail_idx_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// ---------------------------------------------------------------------------
// tb_mem_write_checker
// Directed bench for mem_write_checker. Two checkers share one store bus and
// all control inputs: u_dut (DEPTH=4, TIMEOUT=16) and u_dut_nt (TIMEOUT=0).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_write_checker;
    import mwc_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          start;
    logic [IW:0]   exp_count;
    logic [AW-1:0] ign_lo, ign_hi;
    logic          clear;

    logic          done, pass, done2, pass2;
    logic [1:0]    status, status2;
    logic [IW-1:0] fail_idx, fail_idx2;
    logic [AW-1:0] fail_addr, fail_addr2;
    logic [DW-1:0] fail_data, fail_data2;
    logic [IW:0]   match_cnt, match_cnt2;

    int total = 0;
    int bad   = 0;

    mem_write_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start),
        .exp_count(exp_count), .ign_lo(ign_lo), .ign_hi(ign_hi), .clear(clear),
        .bus(bus), .done(done), .pass(pass), .status(status),
        .fail_idx(fail_idx), .fail_addr(fail_addr), .fail_data(fail_data),
        .match_cnt(match_cnt)
    );

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .TIMEOUT(0)) u_dut_nt (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start),
        .exp_count(exp_count), .ign_lo(ign_lo), .ign_hi(ign_hi), .clear(clear),
        .bus(bus), .done(done2), .pass(pass2), .status(status2),
        .fail_idx(fail_idx2), .fail_addr(fail_addr2), .fail_data(fail_data2),
        .match_cnt(match_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [IW-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_chk(input logic [IW:0] cnt, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        exp_count = cnt; ign_lo = lo; ign_hi = hi; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
        tick();
        bus.memwrite = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic load_four();
        load(2'd0, 32'd0, 32'd1);
        load(2'd1, 32'd4, 32'd2);
        load(2'd2, 32'd8, 32'd3);
        load(2'd3, 32'd12, 32'd4);
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; exp_count = '0; ign_lo = '0; ign_hi = '0; clear = 1'b0;
        bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;

        // Reset state
        tick(2);
        check("rst_status", status, ST_RUN);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_fail_addr", fail_addr, 0);
        reset = 1'b1;
        tick();

        // Original program: scratch store to 30 ignored, store to 20 matches
        load(2'd0, 32'd20, 32'd100);
        start_chk(3'd1, 32'd30, 32'd30);
        store(32'd30, 32'd100);
        check("orig_ignored_status", status, ST_RUN);
        check("orig_ignored_cnt", match_cnt, 0);
        store(32'd20, 32'd100);
        check("orig_status", status, ST_PASS);
        check("orig_pass", pass, 1'b1);
        check("orig_done", done, 1'b1);
        check("orig_match_cnt", match_cnt, 1);
        store(32'd77, 32'd5);
        check("orig_sticky", status, ST_PASS);

        // Expected data 99, bus writes 100
        do_clear();
        check("clear_status", status, ST_RUN);
        check("clear_done", done, 1'b0);
        load(2'd0, 32'd20, 32'd99);
        start_chk(3'd1, 32'd30, 32'd30);
        store(32'd20, 32'd100);
        check("bad_data_status", status, ST_MISMATCH);
        check("bad_data_idx", fail_idx, 0);
        check("bad_data_addr", fail_addr, 20);
        check("bad_data_data", fail_data, 100);
        check("bad_data_pass", pass, 1'b0);

        // Store to 24 outside the window
        do_clear();
        load(2'd0, 32'd20, 32'd100);
        start_chk(3'd1, 32'd30, 32'd30);
        store(32'd24, 32'd100);
        check("bad_addr_status", status, ST_MISMATCH);
        check("bad_addr_addr", fail_addr, 24);

        // Table write and start in the same cycle; start sees the new entry
        do_clear();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'd40; cfg_data = 32'd7;
        exp_count = 3'd1; ign_lo = 32'd1; ign_hi = 32'd0; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        store(32'd40, 32'd7);
        check("we_start_status", status, ST_PASS);

        // Four ordered stores with idle gaps, empty ignore window
        do_clear();
        load_four();
        start_chk(3'd4, 32'd1, 32'd0);
        store(32'd0, 32'd1);  tick(2);
        store(32'd4, 32'd2);  tick(2);
        store(32'd8, 32'd3);  tick(2);
        check("order_mid_status", status, ST_RUN);
        check("order_mid_cnt", match_cnt, 3);
        store(32'd12, 32'd4);
        check("order_status", status, ST_PASS);
        check("order_cnt", match_cnt, 4);

        // Entries 2 and 3 swapped (table retained)
        do_clear();
        start_chk(3'd4, 32'd1, 32'd0);
        store(32'd0, 32'd1);
        store(32'd8, 32'd3);
        check("swap_status", status, ST_MISMATCH);
        check("swap_idx", fail_idx, 1);
        check("swap_addr", fail_addr, 8);
        check("swap_data", fail_data, 3);

        // exp_count above DEPTH clamps to DEPTH
        do_clear();
        start_chk(3'd7, 32'd1, 32'd0);
        store(32'd0, 32'd1);
        store(32'd4, 32'd2);
        store(32'd8, 32'd3);
        store(32'd12, 32'd4);
        check("clamp_status", status, ST_PASS);
        check("clamp_cnt", match_cnt, 4);

        // Timeout with no stores: fires on the 16th edge after start
        do_clear();
        start_chk(3'd4, 32'd1, 32'd0);
        tick(15);
        check("tmo_early", status, ST_RUN);
        tick(1);
        check("tmo_status", status, ST_TIMEOUT);
        check("tmo_done", done, 1'b1);
        check("tmo_idx", fail_idx, 0);
        check("tmo_addr", fail_addr, 0);
        check("tmo_nt_status", status2, ST_RUN);

        // Match at cycle 10 restarts the timer: timeout at cycle 26
        do_clear();
        start_chk(3'd4, 32'd1, 32'd0);
        tick(9);
        store(32'd0, 32'd1);
        tick(15);
        check("tmo2_early", status, ST_RUN);
        check("tmo2_cnt", match_cnt, 1);
        tick(1);
        check("tmo2_status", status, ST_TIMEOUT);
        check("tmo2_idx", fail_idx, 1);
        check("tmo2_data", fail_data, 0);

        // TIMEOUT=0 instance never times out
        do_clear();
        start_chk(3'd4, 32'd1, 32'd0);
        tick(1000);
        check("nt_status", status2, ST_RUN);
        check("nt_done", done2, 1'b0);

        // exp_count of zero passes on the start edge
        do_clear();
        start_chk(3'd0, 32'd1, 32'd0);
        check("zero_status", status, ST_PASS);
        check("zero_pass", pass, 1'b1);

        // clear beats start in IDLE
        do_clear();
        exp_count = 3'd0; start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check("clear_beats_start", status, ST_RUN);
        check("clear_beats_start_done", done, 1'b0);

        // Reset mid-run aborts; re-run with the retained table
        start_chk(3'd4, 32'd1, 32'd0);
        store(32'd0, 32'd1);
        store(32'd4, 32'd2);
        check("abort_pre_cnt", match_cnt, 2);
        reset = 1'b0;
        tick();
        check("abort_cnt", match_cnt, 0);
        check("abort_status", status, ST_RUN);
        check("abort_done", done, 1'b0);
        reset = 1'b1;
        start_chk(3'd4, 32'd1, 32'd0);
        store(32'd0, 32'd1);
        store(32'd4, 32'd2);
        store(32'd8, 32'd3);
        store(32'd12, 32'd4);
        check("rerun_status", status, ST_PASS);
        check("rerun_pass", pass, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesisable, self-checking monitor for the single-cycle processor's data-memory write port (memwrite/dataadr/writedata from top).
- Replaces hard-coded "address X == value Y" bench checks with a loadable, ordered table of expected stores, an ignore window for scratch stores, and a timeout.
- Sits beside top in the bench or an FPGA harness; it reports pass, mismatch or timeout with captured failure details.

Parameters:
- ADDR_W, 32, width of dataadr and table addresses
- DATA_W, 32, width of writedata and table data
- DEPTH, 8, maximum expected-store entries (power of 2, >=2); IDX_W = $clog2(DEPTH)
- TIMEOUT, 1024, cycles allowed without a matching store before a timeout; 0 disables the timeout

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- cfg_we  in  1  write one expected-table entry (honoured only in IDLE)
- cfg_idx  in  IDX_W  entry index to write
- cfg_addr  in  ADDR_W  expected store address
- cfg_data  in  DATA_W  expected store data
- start  in  1  begin checking (honoured only in IDLE)
- exp_count  in  IDX_W+1  number of valid entries, sampled on start; clamped to DEPTH
- ign_lo, ign_hi  in  ADDR_W  inclusive ignore window, sampled on start; window is empty if ign_lo > ign_hi
- clear  in  1  return from any state to IDLE
- memwrite  in  1  DUT store strobe
- dataadr  in  ADDR_W  DUT store address
- writedata  in  DATA_W  DUT store data
- done  out  1  high in PASS/FAIL/TMO
- pass  out  1  high only in PASS
- status  out  2  00 idle/run, 01 pass, 10 mismatch, 11 timeout
- fail_idx  out  IDX_W  entry index that was expected at failure
- fail_addr  out  ADDR_W  captured dataadr at mismatch (0 on timeout)
- fail_data  out  DATA_W  captured writedata at mismatch (0 on timeout)
- match_cnt  out  IDX_W+1  entries matched so far

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All outputs are 0. exp_count reg, ptr, timer and ignore regs are 0. Table RAM contents are not cleared.
- States: IDLE, RUN, PASS, FAIL, TMO. Registered single-process FSM; every output is a register.
- IDLE:
  - cfg_we writes table[cfg_idx] at the edge.
  - start latches exp_count, ign_lo and ign_hi, clears ptr, match_cnt and timer, then goes to RUN.
  - If the latched count is 0, go directly to PASS instead.
  - cfg_we and start in the same cycle: the write completes first, and start sees the new entry.
- RUN: a store is sampled at a rising edge when memwrite==1.
  - dataadr inside [ign_lo, ign_hi]: the store is ignored. The timer is not reset.
  - Otherwise the store is compared with table[ptr], address and data both exact.
  - Match: ptr and match_cnt increment and the timer clears. If ptr was count-1, go to PASS.
  - Mismatch: go to FAIL with status=10, fail_idx=ptr, and fail_addr/fail_data = the sampled bus.
- Timer (RUN only, TIMEOUT>0): increments every cycle without a match. Reaching TIMEOUT goes to TMO with status=11, fail_idx=ptr, fail_addr=fail_data=0.
  - A store sampled in the same cycle the timer expires takes priority.
- Latency: done, pass and status update on the edge that samples the deciding store (visible the following cycle). The timeout fires exactly TIMEOUT cycles after start or after the last match.
- PASS/FAIL/TMO are sticky. Further stores, cfg_we and start are ignored. Only clear or reset leaves these states.
- clear: goes to IDLE and zeros all outputs; the table is kept. clear beats start in the same cycle.
- Reset or clear mid-RUN aborts the check with no verdict.
- Comparisons use === semantics in simulation. A sampled X or Z on dataadr or writedata counts as a mismatch.

Decomposition:
- Shared package mwc_pkg holds:
  - the state enum (IDLE, RUN, PASS, FAIL, TMO)
  - the status code constants ST_RUN, ST_PASS, ST_MISMATCH, ST_TIMEOUT
- One sub-module, mwc_table: DEPTH x (ADDR_W+DATA_W) RAM with one synchronous write port and one combinational read port indexed by ptr.

Test Plan:
- Original program (addi; sw 30; lw 30; sw 20), table {0:(20,100)}, count=1, ignore [30,30]: stores (30,100) then (20,100) -> PASS, pass=1, match_cnt=1.
- Same program, table data 99: store (20,100) -> status=10, fail_idx=0, fail_addr=20, fail_data=100.
- Store to address 24 with ignore [30,30] and table {(20,100)} -> FAIL, fail_addr=24.
- DEPTH=4 table {(0,1),(4,2),(8,3),(12,4)}, count=4, stores in order with idle gaps -> PASS after the 4th store. The same stores with 2 and 3 swapped -> FAIL, fail_idx=1.
- TIMEOUT=16, start with no stores -> status=11 exactly 16 cycles after start. One match at cycle 10 -> status=11 at cycle 26. TIMEOUT=0 -> stays in RUN for 1000 cycles.
- count=0 -> PASS one cycle after start. Reset low during RUN after 2 matches -> all outputs 0 next cycle. Re-start with the table retained -> PASS.
